// File: rtl/disp_pkg.sv
// Shared constants for the 6-digit 7-segment display path: blank code,
// segment table and digit positions.
package disp_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    // Segment order {a,b,c,d,e,f,g}, 1 = lit
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b111_1110, 7'b011_0000, 7'b110_1101, 7'b111_1001, 7'b011_0011,
        7'b101_1011, 7'b101_1111, 7'b111_0000, 7'b111_1111, 7'b111_1011
    };

    localparam logic [2:0] DIG_HT = 3'd0;
    localparam logic [2:0] DIG_HO = 3'd1;
    localparam logic [2:0] DIG_MT = 3'd2;
    localparam logic [2:0] DIG_MO = 3'd3;
    localparam logic [2:0] DIG_ST = 3'd4;
    localparam logic [2:0] DIG_SO = 3'd5;

    function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [2:0] idx);
        return NUM_DIGITS'(1) << idx;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD to 7-segment decoder; codes above 9 produce a dark digit.
module bcd_to_seg7
    import disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= 4'd9) begin
            seg = SEG_DIGIT[bcd];
        end
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Multiplexed 6-digit 7-segment scanner with per-frame snapshot, dead time,
// 4-level brightness PWM and leading-zero suppression.
module bcd_scan_display
    import disp_pkg::*;
#(
    parameter int SCAN_DIV       = 16,
    parameter int DEAD_CYCLES    = 1,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [3:0]            hour_tens,
    input  logic [3:0]            hour_ones,
    input  logic [3:0]            min_tens,
    input  logic [3:0]            min_ones,
    input  logic [3:0]            sec_tens,
    input  logic [3:0]            sec_ones,
    input  logic                  colon_on,
    input  logic                  lz_en,
    input  logic [1:0]            bright,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  frame_start
);

    localparam int CNT_W   = $clog2(SCAN_DIV);
    localparam int QUARTER = SCAN_DIV / 4;

    logic [CNT_W-1:0] slot_cnt_reg;
    logic [2:0]       digit_idx_reg;
    logic             slot_last;
    logic             frame_last;

    logic [3:0] digit_in     [NUM_DIGITS];
    logic [3:0] shadow_digit [NUM_DIGITS];
    logic       shadow_colon_reg;
    logic       shadow_lz_reg;
    logic [1:0] shadow_bright_reg;
    logic       shadow_valid_reg;

    assign digit_in[DIG_HT] = hour_tens;
    assign digit_in[DIG_HO] = hour_ones;
    assign digit_in[DIG_MT] = min_tens;
    assign digit_in[DIG_MO] = min_ones;
    assign digit_in[DIG_ST] = sec_tens;
    assign digit_in[DIG_SO] = sec_ones;

    assign slot_last  = (slot_cnt_reg == CNT_W'(SCAN_DIV - 1));
    assign frame_last = slot_last && (digit_idx_reg == DIG_SO);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_reg  <= '0;
            digit_idx_reg <= DIG_HT;
        end else begin
            slot_cnt_reg <= slot_last ? '0 : slot_cnt_reg + CNT_W'(1);
            if (slot_last) begin
                digit_idx_reg <= (digit_idx_reg == DIG_SO) ? DIG_HT : digit_idx_reg + 3'd1;
            end
        end
    end

    // Inputs are sampled only in the last cycle of a frame so a frame never tears
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_shadow
        logic [3:0] digit_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                digit_reg <= BCD_BLANK;
            end else if (frame_last) begin
                digit_reg <= digit_in[gi];
            end
        end

        assign shadow_digit[gi] = digit_reg;
    end

    // shadow_valid keeps the post-reset frame fully dark until a real snapshot exists
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_colon_reg  <= 1'b0;
            shadow_lz_reg     <= 1'b0;
            shadow_bright_reg <= 2'd0;
            shadow_valid_reg  <= 1'b0;
        end else if (frame_last) begin
            shadow_colon_reg  <= colon_on;
            shadow_lz_reg     <= lz_en;
            shadow_bright_reg <= bright;
            shadow_valid_reg  <= 1'b1;
        end
    end

    logic [3:0]            cur_bcd;
    logic [6:0]            dec_seg;
    logic [CNT_W-1:0]      quarter;
    logic                  lz_blank;
    logic                  slot_on;
    logic [6:0]            seg_next;
    logic                  dp_next;
    logic [NUM_DIGITS-1:0] dig_en_next;
    logic                  frame_start_next;

    assign cur_bcd = shadow_digit[digit_idx_reg];

    bcd_to_seg7 u_dec (
        .bcd (cur_bcd),
        .seg (dec_seg)
    );

    assign quarter  = slot_cnt_reg / CNT_W'(QUARTER);
    assign lz_blank = shadow_lz_reg && (digit_idx_reg == DIG_HT) && (cur_bcd == 4'd0);
    assign slot_on  = en && shadow_valid_reg
                   && (slot_cnt_reg >= CNT_W'(DEAD_CYCLES))
                   && (quarter <= CNT_W'(shadow_bright_reg));

    always_comb begin
        seg_next         = SEG_BLANK;
        dp_next          = 1'b0;
        dig_en_next      = '0;
        frame_start_next = (slot_cnt_reg == '0) && (digit_idx_reg == DIG_HT);
        if (slot_on) begin
            seg_next    = lz_blank ? SEG_BLANK : dec_seg;
            dp_next     = shadow_colon_reg && (digit_idx_reg == DIG_HO || digit_idx_reg == DIG_MO);
            dig_en_next = digit_onehot(digit_idx_reg);
        end
    end

    logic [6:0]            seg_reg;
    logic                  dp_reg;
    logic [NUM_DIGITS-1:0] dig_en_reg;
    logic                  frame_start_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_reg         <= {7{SEG_ACTIVE_LOW}};
            dp_reg          <= SEG_ACTIVE_LOW;
            dig_en_reg      <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
            frame_start_reg <= 1'b0;
        end else begin
            seg_reg         <= seg_next ^ {7{SEG_ACTIVE_LOW}};
            dp_reg          <= dp_next ^ SEG_ACTIVE_LOW;
            dig_en_reg      <= dig_en_next ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
            frame_start_reg <= frame_start_next;
        end
    end

    assign seg         = seg_reg;
    assign dp          = dp_reg;
    assign dig_en      = dig_en_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display: the driver pushes the expected output
// of every clock, a monitor pops and compares one cycle later.
module tb_bcd_scan_display;

    localparam int SD = 8;
    localparam int DC = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en;
    logic [3:0] ht, ho, mt, mo, st, so;
    logic       colon_on, lz_en;
    logic [1:0] bright;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] dig_en;
    logic       frame_start;

    bcd_scan_display #(
        .SCAN_DIV       (SD),
        .DEAD_CYCLES    (DC),
        .SEG_ACTIVE_LOW (1'b0),
        .DIG_ACTIVE_LOW (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .hour_tens   (ht),
        .hour_ones   (ho),
        .min_tens    (mt),
        .min_ones    (mo),
        .sec_tens    (st),
        .sec_ones    (so),
        .colon_on    (colon_on),
        .lz_en       (lz_en),
        .bright      (bright),
        .seg         (seg),
        .dp          (dp),
        .dig_en      (dig_en),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [5:0] dig;
        logic       fs;
    } out_t;

    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0] seg_tab [10];

    int         m_slot = 0;
    int         m_dig  = 0;
    logic [3:0] m_sh [6];
    logic       m_colon, m_lz, m_valid;
    logic [1:0] m_bright;

    int         on_cnt = 0, fs_cnt = 0, dp_cnt = 0, pop_cnt = 0;
    logic [6:0] seg0_seen = '0, seg3_seen = '0, seg4_seen = '0;

    task automatic model_reset();
        m_slot = 0;
        m_dig  = 0;
        for (int i = 0; i < 6; i++) m_sh[i] = 4'hF;
        m_colon  = 1'b0;
        m_lz     = 1'b0;
        m_bright = 2'd0;
        m_valid  = 1'b0;
    endtask

    // Push the output expected after the coming posedge, advance the model,
    // then wait for the next negedge.
    task automatic cycle();
        out_t       e;
        logic [3:0] v;
        logic       on;
        e = '0;
        if (!rst) begin
            v    = m_sh[m_dig];
            on   = en && m_valid && (m_slot >= DC) && ((m_slot / (SD / 4)) <= int'(m_bright));
            e.fs = (m_slot == 0) && (m_dig == 0);
            if (on) begin
                e.dig = 6'b000001 << m_dig;
                e.seg = (v <= 4'd9 && !(m_dig == 0 && m_lz && v == 4'd0)) ? seg_tab[int'(v)] : 7'b0;
                e.dp  = m_colon && (m_dig == 1 || m_dig == 3);
            end
        end
        exp_q.push_back(e);
        if (rst) begin
            model_reset();
        end else begin
            if (m_dig == 5 && m_slot == SD - 1) begin
                m_sh[0] = ht; m_sh[1] = ho; m_sh[2] = mt;
                m_sh[3] = mo; m_sh[4] = st; m_sh[5] = so;
                m_colon = colon_on; m_lz = lz_en; m_bright = bright; m_valid = 1'b1;
            end
            if (m_slot == SD - 1) begin
                m_slot = 0;
                m_dig  = (m_dig == 5) ? 0 : m_dig + 1;
            end else begin
                m_slot++;
            end
        end
        @(negedge clk);
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end else begin
            $display("ok   %s = %0d", name, got);
        end
    endtask

    // Monitor: one comparison per output cycle
    always begin
        out_t e;
        out_t got;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {seg, dp, dig_en, frame_start};
            pop_cnt++;
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL out cyc=%0d got seg=%b dp=%b dig=%b fs=%b expected seg=%b dp=%b dig=%b fs=%b",
                         pop_cnt, got.seg, got.dp, got.dig, got.fs, e.seg, e.dp, e.dig, e.fs);
            end
            if (dig_en != 6'b0) on_cnt++;
            if (frame_start)    fs_cnt++;
            if (dp)             dp_cnt++;
            if (dig_en == 6'b000001) seg0_seen = seg;
            if (dig_en == 6'b001000) seg3_seen = seg;
            if (dig_en == 6'b010000) seg4_seen = seg;
        end
    end

    initial begin
        int base_on, base_fs, base_dp;
        int bl [3];
        int bexp [3];
        seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
        bl   = '{0, 1, 3};
        bexp = '{6, 18, 42};
        ht = 4'd1; ho = 4'd2; mt = 4'd3; mo = 4'd4; st = 4'd5; so = 4'd6;
        colon_on = 1'b0; lz_en = 1'b0; bright = 2'd3; en = 1'b1; rst = 1'b1;
        model_reset();

        @(negedge clk);
        repeat (3) cycle();
        rst = 1'b0;

        // First frame after reset is dark; frame_start marks its start
        base_on = on_cnt; base_fs = fs_cnt;
        repeat (48) cycle();
        check("first_frame_dark", on_cnt - base_on, 0);
        check("first_frame_fs", fs_cnt - base_fs, 1);

        base_on = on_cnt; base_fs = fs_cnt;
        repeat (96) cycle();
        check("scan_on_cycles_2frames", on_cnt - base_on, 84);
        check("scan_fs_2frames", fs_cnt - base_fs, 2);
        check("digit0_pattern", seg0_seen, 7'b0110000);

        // Change min_ones mid-frame: current frame keeps 4, next frame shows 9
        while (m_dig != 1) cycle();
        mo = 4'd9;
        while (m_dig != 4) cycle();
        check("no_tear_old_digit3", seg3_seen, 7'b0110011);
        while (m_dig != 5) cycle();
        while (m_dig != 4) cycle();
        check("no_tear_new_digit3", seg3_seen, 7'b1111011);

        for (int i = 0; i < 3; i++) begin
            bright = bl[i][1:0];
            repeat (96) cycle();
            base_on = on_cnt;
            repeat (48) cycle();
            check($sformatf("bright%0d_on_cycles", bl[i]), on_cnt - base_on, bexp[i]);
        end

        // Leading zero, blank code and colon
        ht = 4'd0; lz_en = 1'b1; st = 4'hF; colon_on = 1'b1;
        repeat (96) cycle();
        base_on = on_cnt; base_dp = dp_cnt;
        repeat (48) cycle();
        check("colon_dp_cycles", dp_cnt - base_dp, 14);
        check("lz_digit0_seg", seg0_seen, 0);
        check("blank_digit4_seg", seg4_seen, 0);
        check("blank_digits_still_enabled", on_cnt - base_on, 42);

        // Reset during digit 3, then a dark restart frame
        while (m_dig != 3) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        base_on = on_cnt; base_fs = fs_cnt;
        repeat (48) cycle();
        check("after_rst_dark", on_cnt - base_on, 0);
        check("after_rst_fs", fs_cnt - base_fs, 1);

        en = 1'b0;
        repeat (48) cycle();
        base_on = on_cnt; base_fs = fs_cnt;
        repeat (96) cycle();
        check("en0_no_digits", on_cnt - base_on, 0);
        check("en0_fs_still_pulses", fs_cnt - base_fs, 2);

        en = 1'b1;
        repeat (96) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
